// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared op encodings, state enum and sizing for the RV32M divider.
package div_unit_pkg;
  localparam int DIV_XLEN = 32;
  localparam int ITER = DIV_XLEN;
  typedef enum logic [1:0] {DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3} div_op_e;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} div_state_e;
endpackage

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_A,
  input  logic [XLEN-1:0] i_B,
  input  logic            i_flush,
  output logic            o_valid,
  output logic [XLEN-1:0] o_out
);
  localparam int CW = $clog2(XLEN) + 1;
  div_state_e state;
  logic [XLEN-1:0] quo, rem, dvs;
  logic [CW-1:0] cnt;
  logic rem_sel, neg, spc;
  logic is_signed, a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] a_mag, b_mag, nquo, nrem, res;
  logic [XLEN:0] sh, diff;
  always_comb begin
    is_signed = ~i_op[0];
    a_neg = is_signed & i_A[XLEN-1];
    b_neg = is_signed & i_B[XLEN-1];
    a_mag = a_neg ? -i_A : i_A;
    b_mag = b_neg ? -i_B : i_B;
    div0 = i_B == '0;
    ovf = is_signed & (i_A == {1'b1, {(XLEN-1){1'b0}}}) & (&i_B);
    sh = {rem, quo[XLEN-1]};
    diff = sh - {1'b0, dvs};
    nrem = spc ? rem : (diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0]);
    nquo = spc ? quo : {quo[XLEN-2:0], ~diff[XLEN]};
    res = rem_sel ? nrem : nquo;
    res = neg ? -res : res;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_out <= '0;
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
      rem_sel <= 1'b0;
      neg <= 1'b0;
      spc <= 1'b0;
    end else if (i_flush) begin
      state <= IDLE;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          state <= BUSY;
          o_ready <= 1'b0;
          rem_sel <= i_op[1];
          dvs <= b_mag;
          // special cases carry their final result and take a single pass through BUSY
          spc <= div0 | ovf;
          neg <= (div0 | ovf) ? 1'b0 : (i_op[1] ? a_neg : a_neg ^ b_neg);
          cnt <= (div0 | ovf) ? CW'(ITER - 1) : '0;
          quo <= div0 ? '1 : (ovf ? {1'b1, {(XLEN-1){1'b0}}} : a_mag);
          rem <= div0 ? i_A : '0;
        end
        BUSY: begin
          quo <= nquo;
          rem <= nrem;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(ITER - 1)) begin
            state <= DONE;
            o_valid <= 1'b1;
            o_out <= res;
          end
        end
        default: begin
          state <= IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
